card_shuffler: RTL

CARD_SHUFFLER -- requirements
Module: card_shuffler

---
 rtl/card_shuffler_if.sv | 32 +++
 rtl/card_shuffler.sv | 132 +++++++++++++
 2 files changed

// File: rtl/card_shuffler_if.sv
// card_shuffler_if
//   Handshake bundle between a card_shuffler and its controller.
//   master : drives shuffle_start, seed, card_start; observes status/card.
//   slave  : the shuffler itself.
//   Signals:
//     shuffle_start / seed[5:0]       shuffle request (level) and its seed
//     shuffle_ready / shuffling       idle vs. shuffle in progress (complements)
//     card_start                      deal request (level)
//     card_ready / card[3:0]          deal handshake and dealt rank (0 = none)
//     card_overflow                   sticky empty-deck request flag
//     cards_left[5:0]                 undealt cards, 0..52
interface card_shuffler_if;
  logic       shuffle_start;
  logic [5:0] seed;
  logic       shuffle_ready;
  logic       shuffling;
  logic       card_start;
  logic       card_ready;
  logic [3:0] card;
  logic       card_overflow;
  logic [5:0] cards_left;

  modport master (
    output shuffle_start, seed, card_start,
    input  shuffle_ready, shuffling, card_ready, card, card_overflow, cards_left
  );

  modport slave (
    input  shuffle_start, seed, card_start,
    output shuffle_ready, shuffling, card_ready, card, card_overflow, cards_left
  );
endinterface

// File: rtl/card_shuffler.sv
// card_shuffler
//   Builds a 52-card deck (four runs of ranks 1..13), shuffles it with a
//   Fisher-Yates walk driven by a 16-bit LFSR using rejection sampling, and
//   deals one card per card_start handshake.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous, active-low reset
//     bus  : card_shuffler_if.slave (requests in, status/card out)
module card_shuffler (
  input  logic            clk,
  input  logic            rst,
  card_shuffler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, INIT, SWAP, DEAL} state_e;

  state_e      state_q, state_d;
  logic [3:0]  deck_q [52];
  logic [3:0]  deck_d [52];
  logic [5:0]  ptr_q, ptr_d;
  logic [5:0]  i_q, i_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  card_q, card_d;
  logic        ovf_q, ovf_d;
  logic [5:0]  r;

  // Fibonacci LFSR, taps 16,14,13,11 (maximal length).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Fresh-deck rank for slot idx: (idx mod 13) + 1.
  function automatic logic [3:0] rank_of(input logic [5:0] idx);
    logic [5:0] m;
    m = idx % 6'd13;
    return m[3:0] + 4'd1;
  endfunction

  assign r = lfsr_q[5:0];

  always_comb begin
    state_d = state_q;
    deck_d  = deck_q;
    ptr_d   = ptr_q;
    i_d     = i_q;
    lfsr_d  = lfsr_q;
    card_d  = card_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        // A shuffle request wins over a simultaneous deal request.
        if (bus.shuffle_start) begin
          state_d = INIT;
          lfsr_d  = {bus.seed, 10'b1010110011};
          i_d     = 6'd0;
        end else if (bus.card_start) begin
          state_d = DEAL;
          if (ptr_q < 6'd52) begin
            card_d = deck_q[ptr_q];
            ptr_d  = ptr_q + 6'd1;
          end else begin
            card_d = 4'd0;
            ovf_d  = 1'b1;
          end
        end
      end
      INIT: begin
        deck_d[i_q] = rank_of(i_q);
        if (i_q == 6'd51) begin
          state_d = SWAP;
        end else begin
          i_d = i_q + 6'd1;
        end
      end
      SWAP: begin
        lfsr_d = lfsr_step(lfsr_q);
        // Draws above i are rejected and retried with the next LFSR value,
        // keeping the permutation free of modulo bias.
        if (r <= i_q) begin
          deck_d[i_q] = deck_q[r];
          deck_d[r]   = deck_q[i_q];
          if (i_q == 6'd1) begin
            state_d = IDLE;
            ptr_d   = 6'd0;
            ovf_d   = 1'b0;
            card_d  = 4'd0;
          end else begin
            i_d = i_q - 6'd1;
          end
        end
      end
      DEAL: begin
        // One card per assertion: wait for the request to drop.
        if (!bus.card_start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 6'd52;
      i_q     <= 6'd0;
      lfsr_q  <= 16'h0001;
      card_q  <= 4'd0;
      ovf_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      i_q     <= i_d;
      lfsr_q  <= lfsr_d;
      card_q  <= card_d;
      ovf_q   <= ovf_d;
    end
  end

  // Deck contents are not reset; ptr=52 after reset makes them unreachable.
  always_ff @(posedge clk) begin
    deck_q <= deck_d;
  end

  assign bus.shuffling     = (state_q == INIT) || (state_q == SWAP);
  assign bus.shuffle_ready = !bus.shuffling;
  assign bus.card_ready    = (state_q != DEAL);
  assign bus.card          = card_q;
  assign bus.card_overflow = ovf_q;
  assign bus.cards_left    = 6'd52 - ptr_q;

endmodule
